zwait_service: RTL and testbench

ZWAIT_SERVICE -- requirements
Module: zwait_service

---
 rtl/zwait_service.sv | 142 ++++++++++++++
 tb/tb_zwait_service.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zwait_service.sv
// zwait_service: picks one pending Z80 wait source at a time, presents it to
// the MCU as a service request, and on acknowledge emits a fixed-length
// wait_end release pulse. It then waits for the source to drop before
// returning to IDLE.
// Optional feature macro: ZWAIT_SVC_TIMEOUT_EN. It adds a PEND timeout that
// forces the release pulse and raises a sticky svc_timeout flag.
// Handshake: svc_req is held high while in PEND with svc_src stable. A
// one-cycle svc_ack seen at a rising edge while svc_req=1, and while the
// source is still pending, is accepted. svc_ack at any other time is ignored.
module zwait_service #(
  parameter int unsigned END_LEN   = 4,
  parameter logic [15:0] TO_CYCLES = 16'd1024
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic [6:0] waits,
  input  logic       svc_ack,
  output logic       svc_req,
  output logic [2:0] svc_src,
  output logic       wait_end,
  output logic       svc_busy,
  output logic       svc_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_END   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] ws_meta_q, ws_q;
  logic [2:0] src_q, src_d;
  logic [3:0] end_cnt_q, end_cnt_d;
  logic       src_live;
  logic       to_hit;

  // The latched source is still asking for service.
  assign src_live = ws_q[src_q];

  // Lowest set index; the loop runs downward so the lowest index wins.
  function automatic logic [2:0] lowest_idx(input logic [6:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizer for the asynchronous wait flags.
  always_ff @(posedge fclk) begin
    if (rst) begin
      ws_meta_q <= '0;
      ws_q      <= '0;
    end else begin
      ws_meta_q <= waits;
      ws_q      <= ws_meta_q;
    end
  end

  // State, source latch and end-pulse counter registers.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      end_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      end_cnt_q <= end_cnt_d;
    end
  end

  // Next-state logic. Source release in PEND takes priority over ack and timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ws_q != 7'd0) state_d = S_PEND;
      S_PEND: begin
        if (!src_live)              state_d = S_IDLE;
        else if (svc_ack || to_hit) state_d = S_END;
      end
      S_END:   if (end_cnt_q == 4'd1) state_d = S_DRAIN;
      S_DRAIN: if (!src_live) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Source capture in IDLE. The end counter loads on entry to END and counts down while in END.
  always_comb begin
    src_d     = src_q;
    end_cnt_d = end_cnt_q;
    if (state_q == S_IDLE && ws_q != 7'd0) src_d = lowest_idx(ws_q);
    if (state_q == S_PEND && state_d == S_END) end_cnt_d = 4'(END_LEN);
    else if (state_q == S_END)                 end_cnt_d = end_cnt_q - 4'd1;
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    svc_req  = (state_q == S_PEND);
    wait_end = (state_q == S_END);
    svc_busy = (state_q != S_IDLE);
    svc_src  = src_q;
  end

`ifdef ZWAIT_SVC_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
  logic        ack_take;

  assign ack_take    = (state_q == S_PEND) && src_live && svc_ack;
  // The timeout fires on the TO_CYCLES-th PEND cycle.
  assign to_hit      = (state_q == S_PEND) && (to_cnt_q == TO_CYCLES - 16'd1);
  assign svc_timeout = timeout_q;

  // PEND cycle counter, held at zero outside PEND. The sticky flag is cleared only by an accepted ack.
  always_comb begin
    to_cnt_d  = (state_q == S_PEND) ? to_cnt_q + 16'd1 : 16'd0;
    timeout_d = timeout_q;
    if (ack_take)                timeout_d = 1'b0;
    else if (to_hit && src_live) timeout_d = 1'b1;
  end

  // Timeout counter and sticky flag registers.
  always_ff @(posedge fclk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  // Without the timeout feature, PEND waits indefinitely. TO_CYCLES is folded away here.
  assign to_hit      = 1'b0;
  assign svc_timeout = 1'b0 & (|TO_CYCLES);
`endif

endmodule

// File: tb/tb_zwait_service.sv
// Bench for zwait_service: directed scenarios plus randomized wait masks.
// The expected service order comes from a mask model (lowest pending bit first).
// A negedge monitor pops that order when svc_req rises and checks the pulse
// length, src stability and the idle gap between services.
module tb_zwait_service;
  localparam int END_LEN = 4;
`ifdef ZWAIT_SVC_TIMEOUT_EN
  localparam logic [15:0] TO_CYCLES = 16'd16;
`else
  localparam logic [15:0] TO_CYCLES = 16'd1024;
`endif

  logic       fclk = 1'b0;
  logic       rst;
  logic [6:0] waits;
  logic       svc_ack;
  logic       svc_req;
  logic [2:0] svc_src;
  logic       wait_end;
  logic       svc_busy;
  logic       svc_timeout;

  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q[$];
  logic [6:0] model_mask;
  bit         pulse_abort = 1'b0;
  int         pulse_count = 0;

  zwait_service #(.END_LEN(END_LEN), .TO_CYCLES(TO_CYCLES)) dut (
    .fclk(fclk), .rst(rst), .waits(waits), .svc_ack(svc_ack),
    .svc_req(svc_req), .svc_src(svc_src), .wait_end(wait_end),
    .svc_busy(svc_busy), .svc_timeout(svc_timeout)
  );

  // Clock and watchdog.
  always #5 fclk = ~fclk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [6:0] m);
    for (int i = 0; i < 7; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Monitor: scoreboard pop on request, pulse length, src stability and idle gap.
  logic prev_req = 1'b0, prev_busy = 1'b0;
  logic [2:0] prev_src = 3'd0;
  int wcnt = 0;
  always @(negedge fclk) begin
    if (svc_req && !prev_req) begin
      check("idle_gap", 32'(prev_busy), 0);
      if (exp_q.size() == 0) check("unexpected_req", 1, 0);
      else check("svc_src", 32'(svc_src), 32'(exp_q.pop_front()));
    end
    if (svc_req && prev_req) check("src_stable", 32'(svc_src), 32'(prev_src));
    if (svc_req && wait_end) check("req_end_excl", 1, 0);
    if (wait_end) wcnt++;
    else if (wcnt > 0) begin
      if (pulse_abort) pulse_abort = 1'b0;
      else begin
        check("pulse_len", wcnt, END_LEN);
        pulse_count++;
      end
      wcnt = 0;
    end
    prev_req  = svc_req;
    prev_busy = svc_busy;
    prev_src  = svc_src;
  end

  // Driver tasks; all of them start and end at a falling edge.
  task automatic tick();
    @(negedge fclk);
  endtask

  task automatic issue(input logic [6:0] mask);
    model_mask = mask;
    for (int i = 0; i < 7; i++) if (mask[i]) exp_q.push_back(3'(i));
    waits = mask;
  endtask

  task automatic pulse_ack();
    svc_ack = 1'b1;
    tick();
    svc_ack = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 60; i++) begin
      if (svc_req) return;
      tick();
    end
    check("req_wait_expired", 0, 1);
  endtask

  task automatic wait_end_fall();
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (wait_end) seen = 1'b1;
      else if (seen) return;
      tick();
    end
    check("end_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!svc_busy) return;
      tick();
    end
    check("idle_wait_expired", 0, 1);
  endtask

  task automatic serve_one(input int delay);
    wait_req();
    repeat (delay) tick();
    pulse_ack();
    wait_end_fall();
    model_mask[lowest(model_mask)] = 1'b0;
    waits = model_mask;
  endtask

  initial begin
    int n;
    int pc;
    logic [6:0] m;
    rst = 1'b1; waits = '0; svc_ack = 1'b0; model_mask = '0;
    repeat (3) tick();
    check("rst_req", 32'(svc_req), 0);
    check("rst_src", 32'(svc_src), 0);
    check("rst_end", 32'(wait_end), 0);
    check("rst_busy", 32'(svc_busy), 0);
    check("rst_timeout", 32'(svc_timeout), 0);
    rst = 1'b0;
    tick();

    // Basic latency, pulse and release.
    issue(7'b0000001);
    for (n = 1; n <= 10; n++) begin tick(); if (svc_req) break; end
    check("req_latency", n, 3);
    repeat (2) tick();
    pulse_ack();
    check("end_after_ack", 32'(wait_end), 1);
    wait_end_fall();
    model_mask = '0; waits = '0;
    for (n = 1; n <= 10; n++) begin tick(); if (!svc_busy) break; end
    check("drain_release", n, 3);

    // Two simultaneous sources, lowest first.
    tick();
    issue(7'b0000110);
    serve_one(1);
    serve_one(0);
    wait_idle();

    // A lower bit rising during END is serviced in a later pass.
    tick();
    issue(7'b0100000);
    wait_req();
    pulse_ack();
    waits[0] = 1'b1; model_mask[0] = 1'b1; exp_q.push_back(3'd0);
    wait_end_fall();
    model_mask[5] = 1'b0; waits = model_mask;
    serve_one(2);
    wait_idle();

    // Ack while IDLE and while in DRAIN has no effect.
    pc = pulse_count;
    pulse_ack();
    repeat (3) tick();
    check("idle_ack_busy", 32'(svc_busy), 0);
    issue(7'b1000000);
    wait_req();
    pulse_ack();
    wait_end_fall();
    pulse_ack();
    repeat (3) tick();
    check("drain_ack_busy", 32'(svc_busy), 1);
    check("drain_ack_req", 32'(svc_req), 0);
    check("drain_ack_end", 32'(wait_end), 0);
    check("drain_ack_pulses", pulse_count, pc + 1);
    model_mask = '0; waits = '0;
    wait_idle();

    // Source released during PEND: back to IDLE with no pulse.
    tick();
    issue(7'b0001000);
    wait_req();
    pc = pulse_count;
    model_mask = '0; waits = '0;
    for (n = 1; n <= 10; n++) begin tick(); if (!svc_busy) break; end
    check("release_idle", n, 3);
    repeat (4) tick();
    check("release_no_pulse", pulse_count, pc);
    check("release_timeout", 32'(svc_timeout), 0);

    // Reset during the second wait_end cycle, with the source still held.
    issue(7'b0010000);
    wait_req();
    pulse_ack();
    tick();
    pulse_abort = 1'b1;
    rst = 1'b1;
    tick();
    check("midend_rst_end", 32'(wait_end), 0);
    check("midend_rst_busy", 32'(svc_busy), 0);
    exp_q.push_back(3'd4);
    rst = 1'b0;
    for (n = 1; n <= 10; n++) begin tick(); if (svc_req) break; end
    check("post_rst_latency", n, 3);
    serve_one(1);
    wait_idle();

`ifdef ZWAIT_SVC_TIMEOUT_EN
    // No ack: the pulse is forced after TO_CYCLES PEND cycles.
    tick();
    issue(7'b0000100);
    wait_req();
    n = 0;
    for (int i = 0; i < 40 && svc_req; i++) begin n++; tick(); end
    check("to_pend_cycles", n, 16);
    check("to_end", 32'(wait_end), 1);
    check("to_flag", 32'(svc_timeout), 1);
    wait_end_fall();
    model_mask = '0; waits = '0;
    wait_idle();
    check("to_sticky", 32'(svc_timeout), 1);
    issue(7'b0000001);
    serve_one(0);
    check("to_cleared", 32'(svc_timeout), 0);
    wait_idle();
    // Ack in the same cycle the count is reached: the ack wins.
    tick();
    issue(7'b0000010);
    wait_req();
    repeat (15) tick();
    pulse_ack();
    check("to_tie_end", 32'(wait_end), 1);
    check("to_tie_flag", 32'(svc_timeout), 0);
    wait_end_fall();
    model_mask = '0; waits = '0;
    wait_idle();
`endif

    // Randomized masks with random ack delays.
    for (int it = 0; it < 25; it++) begin
      tick();
      m = 7'($urandom_range(1, 127));
      issue(m);
      while (model_mask != 7'd0) serve_one($urandom_range(0, 4));
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
